// File: rtl/mio_bus_arbiter_pkg.sv
// Shared types and constants for the MIO bus arbiter: FSM state type,
// address-space nibbles and the default RAM wait count.
package mio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    // Top address nibbles of the peripheral windows
    localparam logic [3:0] NIB_SEG7_BTN = 4'hE;
    localparam logic [3:0] NIB_GPIO     = 4'hF;

    localparam int RAM_WAIT_DEFAULT = 1;

    function automatic logic is_periph(input logic [3:0] nib, input logic [3:0] periph_nib);
        return nib >= periph_nib;
    endfunction

endpackage

// File: rtl/mio_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last time.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    always_comb begin
        winner = last_grant;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = last_grant;
        endcase
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Arbitrates two requesters onto the single-master MIO bus; one transaction
// at a time through IDLE -> ADDR -> (WAIT) -> RESP, all bus outputs registered.
module mio_bus_arbiter
    import mio_bus_arbiter_pkg::*;
#(
    parameter int         RAM_WAIT   = RAM_WAIT_DEFAULT,
    parameter logic [3:0] PERIPH_NIB = NIB_SEG7_BTN
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic [31:0] bus_addr,
    output logic        bus_mem_w,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,

    output logic        busy,
    output logic        owner
);

    localparam logic [2:0] WAIT_INIT = (RAM_WAIT > 0) ? 3'(RAM_WAIT - 1) : 3'd0;

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic        last_grant;
    logic [2:0]  wait_cnt;
    logic [31:0] rdata_q;
    logic        winner;
    logic        any_req;
    logic        to_wait;

    assign any_req = m0_req | m1_req;

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .winner     (winner)
    );

    // The latched address is on bus_addr during ADDR, so decode straight from it
    assign to_wait = (RAM_WAIT != 0) && !is_periph(bus_addr[31:28], PERIPH_NIB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = to_wait ? ST_WAIT : ST_RESP;
            ST_WAIT: if (wait_cnt == 3'd0) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 3'd0;
            rdata_q    <= 32'd0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_mem_w  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner      <= winner;
                        last_grant <= winner;
                        bus_addr   <= winner ? m1_addr  : m0_addr;
                        bus_wdata  <= winner ? m1_wdata : m0_wdata;
                        bus_mem_w  <= winner ? m1_we    : m0_we;
                    end
                end
                ST_ADDR: begin
                    bus_mem_w <= 1'b0;
                    if (to_wait) wait_cnt <= WAIT_INIT;
                end
                ST_WAIT: begin
                    if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
                end
                default: ;
            endcase
            // Last bus cycle: grab read data and park the bus for RESP
            if (state_nxt == ST_RESP) begin
                rdata_q   <= bus_rdata;
                bus_addr  <= 32'd0;
                bus_wdata <= 32'd0;
                bus_mem_w <= 1'b0;
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign m0_ack   = (state == ST_RESP) && !owner;
    assign m1_ack   = (state == ST_RESP) &&  owner;
    assign m0_rdata = m0_ack ? rdata_q : 32'd0;
    assign m1_rdata = m1_ack ? rdata_q : 32'd0;

endmodule
